// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM states, IF/ID entry layout and the NOP bubble.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: one request per cycle, response some cycles later.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_rvalid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_rvalid);

endinterface

// File: rtl/if_fetch_unit_skid.sv
// One-entry skid buffer catching a fetch response that lands while Decode is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t entry_r;

  // Entry storage: a redirect clear wins over push, push wins over pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_r <= '{instr: 32'h0000_0000, pc: 32'h0000_0000, valid: 1'b0};
    end else if (clear) begin
      entry_r.valid <= 1'b0;
    end else if (push) begin
      entry_r <= din;
    end else if (pop) begin
      entry_r.valid <= 1'b0;
    end else begin
      entry_r <= entry_r;
    end
  end

  assign dout = entry_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem fetch, skid and IF/ID register with branch redirect.
// Optional perf counters are built when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch,
  input  logic [31:0]       branch_target,
  input  logic              stall_id,
  if_fetch_unit_if.master   imem,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  perf_fetched,
  output logic [CNT_W-1:0]  perf_flushed
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, fetch_pc_r, target_s, issue_addr_s;
  logic         kill_r, rvalid_s, deliver_s, issue_s, skid_push_s, skid_pop_s;
  if_id_t       if_id_r, resp_s, skid_out_s, bubble_s;

  assign target_s    = word_align(branch_target);
  assign rvalid_s    = (state_r == WAIT) && imem.imem_rvalid;
  assign deliver_s   = rvalid_s && !kill_r && !branch;
  assign resp_s      = '{instr: imem.imem_rdata, pc: fetch_pc_r, valid: 1'b1};
  assign bubble_s    = '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};
  assign skid_push_s = deliver_s && stall_id;
  assign skid_pop_s  = !branch && !stall_id && skid_out_s.valid;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (skid_push_s),
    .pop   (skid_pop_s),
    .clear (branch),
    .din   (resp_s),
    .dout  (skid_out_s)
  );

  // Next state and fetch issue; a redirect always fetches the target once the bus is free
  always_comb begin
    state_nxt_s  = state_r;
    issue_s      = 1'b0;
    issue_addr_s = branch ? target_s : pc_r;
    case (state_r)
      BOOT: state_nxt_s = REQ;
      REQ: begin
        issue_s     = 1'b1;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (rvalid_s && skid_push_s) begin
          state_nxt_s = HOLD;
        end else if (rvalid_s) begin
          issue_s     = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (branch) begin
          issue_s     = 1'b1;
          state_nxt_s = WAIT;
        end else if (!stall_id) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  assign imem.imem_req  = issue_s;
  assign imem.imem_addr = issue_addr_s;

  // pc_r is the next address to fetch, fetch_pc_r the address of the fetch in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      fetch_pc_r <= RESET_PC;
      kill_r     <= 1'b0;
      if_id_r    <= '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) begin
        fetch_pc_r <= issue_addr_s;
        pc_r       <= issue_addr_s + 32'd4;
      end else if (branch) begin
        pc_r <= target_s;
      end
      if (rvalid_s) begin
        kill_r <= 1'b0;
      end else if (branch && (state_r == WAIT)) begin
        kill_r <= 1'b1;
      end
      if (branch) begin
        if_id_r <= bubble_s;
      end else if (!stall_id) begin
        if (skid_out_s.valid) begin
          if_id_r <= skid_out_s;
        end else if (deliver_s) begin
          if_id_r <= resp_s;
        end else begin
          if_id_r <= bubble_s;
        end
      end
    end
  end

  assign if_id_instr = if_id_r.instr;
  assign if_id_pc    = if_id_r.pc;
  assign if_id_valid = if_id_r.valid;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetched_r, flushed_r;
  logic             load_valid_s, flush_hit_s;

  assign load_valid_s = !branch && !stall_id && (skid_out_s.valid || deliver_s);
  assign flush_hit_s  = branch && (if_id_r.valid || skid_out_s.valid);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_r <= {CNT_W{1'b0}};
      flushed_r <= {CNT_W{1'b0}};
    end else begin
      if (load_valid_s && (fetched_r != {CNT_W{1'b1}})) begin
        fetched_r <= fetched_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_hit_s && (flushed_r != {CNT_W{1'b1}})) begin
        flushed_r <= flushed_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_fetched = fetched_r;
  assign perf_flushed = flushed_r;
`else
  assign perf_fetched = {CNT_W{1'b0}};
  assign perf_flushed = {CNT_W{1'b0}};
`endif

endmodule
